// File: rtl/packet_gate.sv
// packet_gate: stores one fixed-length packet, then forwards it or discards
// it depending on the filter verdict. A verdict that does not arrive in time
// causes a forced drop.
module packet_gate #(
  parameter int unsigned PKT_LEN = 40,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data_in,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic             decision_done,
  input  logic             decision_allowed,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] fwd_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int unsigned PTR_W = $clog2(PKT_LEN);
  localparam int unsigned TMR_W = 16;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PKT_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    WAIT_DEC = 3'd2,
    FORWARD  = 3'd3,
    DROP     = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TMR_W-1:0] timer;
  logic             tmo_flag;
  logic [7:0]       pkt_buf [PKT_LEN];

  logic             wr_en;
  logic [PTR_W-1:0] wr_addr;
  logic             rd_clr;
  logic             rd_inc;
  logic             tmr_clr;
  logic             tmr_inc;
  logic             tmo_set;
  logic             tmo_clr;
  logic             fwd_inc;
  logic             drop_inc;
  logic             tmo_inc;

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, handshake outputs and datapath strobes.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = 8'h00;
    wr_en      = 1'b0;
    wr_addr    = '0;
    rd_clr     = 1'b0;
    rd_inc     = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    tmo_set    = 1'b0;
    tmo_clr    = 1'b0;
    fwd_inc    = 1'b0;
    drop_inc   = 1'b0;
    tmo_inc    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (valid_in) begin
          wr_en      = 1'b1;
          wr_addr    = '0;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        in_ready = 1'b1;
        if (valid_in) begin
          wr_en   = 1'b1;
          wr_addr = wr_ptr;
          if (wr_ptr == LAST_IDX) begin
            tmr_clr    = 1'b1;
            state_next = WAIT_DEC;
          end
        end
      end
      WAIT_DEC: begin
        // A verdict in the final timer cycle still beats the timeout.
        if (decision_done) begin
          tmo_clr = 1'b1;
          if (decision_allowed) begin
            rd_clr     = 1'b1;
            state_next = FORWARD;
          end else begin
            state_next = DROP;
          end
        end else if (timer == TMR_LAST) begin
          tmo_set    = 1'b1;
          state_next = DROP;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      FORWARD: begin
        out_valid = 1'b1;
        out_data  = pkt_buf[rd_ptr];
        out_last  = (rd_ptr == LAST_IDX);
        if (out_ready) begin
          if (rd_ptr == LAST_IDX) begin
            fwd_inc    = 1'b1;
            state_next = IDLE;
          end else begin
            rd_inc = 1'b1;
          end
        end
      end
      DROP: begin
        if (tmo_flag) begin
          tmo_inc = 1'b1;
        end else begin
          drop_inc = 1'b1;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Packet storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pkt_buf[wr_addr] <= data_in;
    end
  end

  // Pointers, wait timer and drop-cause flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      timer    <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_addr + PTR_W'(1);
      end
      if (rd_clr) begin
        rd_ptr <= '0;
      end else if (rd_inc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (tmr_clr) begin
        timer <= '0;
      end else if (tmr_inc) begin
        timer <= timer + TMR_W'(1);
      end
      if (tmo_set) begin
        tmo_flag <= 1'b1;
      end else if (tmo_clr) begin
        tmo_flag <= 1'b0;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_count     <= '0;
      drop_count    <= '0;
      timeout_count <= '0;
    end else begin
      if (fwd_inc && (fwd_count != '1)) begin
        fwd_count <= fwd_count + CNT_W'(1);
      end
      if (drop_inc && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
      if (tmo_inc && (timeout_count != '1)) begin
        timeout_count <= timeout_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_packet_gate.sv
// Bench for packet_gate: directed scenarios followed by randomized packets,
// checked against a packet-level reference model (byte queues and counts).
module tb_packet_gate;

  localparam int unsigned PKT_LEN = 40;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned CNT_W   = 3;
  localparam int          CMAX    = (1 << CNT_W) - 1;

  typedef logic [7:0] byte_q_t [$];

  logic             clk;
  logic             rst;
  logic [7:0]       data_in;
  logic             valid_in;
  logic             in_ready;
  logic             decision_done;
  logic             decision_allowed;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [CNT_W-1:0] fwd_count;
  logic [CNT_W-1:0] drop_count;
  logic [CNT_W-1:0] timeout_count;

  int checks = 0;
  int errors = 0;
  int exp_fwd = 0;
  int exp_drop = 0;
  int exp_tmo = 0;

  packet_gate #(.PKT_LEN(PKT_LEN), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (data_in),
    .valid_in         (valid_in),
    .in_ready         (in_ready),
    .decision_done    (decision_done),
    .decision_allowed (decision_allowed),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .fwd_count        (fwd_count),
    .drop_count       (drop_count),
    .timeout_count    (timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_fwd_count"}, 32'(fwd_count), 32'(sat(exp_fwd)));
    check({tag, "_drop_count"}, 32'(drop_count), 32'(sat(exp_drop)));
    check({tag, "_timeout_count"}, 32'(timeout_count), 32'(sat(exp_tmo)));
  endtask

  function automatic byte_q_t seq_pkt(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(i));
    return q;
  endfunction

  function automatic byte_q_t rand_pkt();
    byte_q_t q;
    for (int i = 0; i < PKT_LEN; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Feed bytes starting at a negedge; a pulse is raised at byte index early_at.
  task automatic send_bytes(input byte_q_t pkt, input int gap_pct, input int early_at);
    for (int i = 0; i < pkt.size(); i++) begin
      for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
        valid_in = 1'b0;
        data_in  = 8'($urandom);
        @(negedge clk);
        check("in_ready_gap", 32'(in_ready), 32'd1);
      end
      valid_in         = 1'b1;
      data_in          = pkt[i];
      decision_done    = (i == early_at);
      decision_allowed = 1'($urandom_range(1));
      check("in_ready_capture", 32'(in_ready), 32'd1);
      check("out_valid_capture", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    valid_in      = 1'b0;
    decision_done = 1'b0;
    data_in       = 8'($urandom);
  endtask

  // Drain a forwarded packet; mode 0 always ready, 1 toggles from 0, 2 random.
  task automatic receive(input byte_q_t pkt, input int mode, output int cycles);
    int idx;
    logic r;
    idx    = 0;
    cycles = 0;
    while (idx < PKT_LEN && cycles < 20 * PKT_LEN) begin
      check("egress_valid", 32'(out_valid), 32'd1);
      check("egress_data", 32'(out_data), 32'(pkt[idx]));
      check("egress_last", 32'(out_last), 32'(idx == PKT_LEN - 1));
      check("in_ready_fwd", 32'(in_ready), 32'd0);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cycles % 2) : 1'($urandom_range(1));
      out_ready        = r;
      decision_done    = 1'($urandom_range(1));
      decision_allowed = 1'($urandom_range(1));
      @(negedge clk);
      if (r) idx++;
      cycles++;
    end
    out_ready     = 1'b0;
    decision_done = 1'b0;
    check("egress_complete", 32'(idx), 32'(PKT_LEN));
    exp_fwd++;
    check("out_valid_after_fwd", 32'(out_valid), 32'd0);
    check("in_ready_after_fwd", 32'(in_ready), 32'd1);
    check_counts("after_fwd");
  endtask

  // Verdict d wait cycles after capture; d >= TIMEOUT means none arrives in time.
  task automatic decide(input byte_q_t pkt, input int d, input logic allowed, input int mode);
    int cyc;
    check("in_ready_wait", 32'(in_ready), 32'd0);
    if (d < TIMEOUT) begin
      repeat (d) begin
        check("out_valid_wait", 32'(out_valid), 32'd0);
        @(negedge clk);
      end
      decision_done    = 1'b1;
      decision_allowed = allowed;
      @(negedge clk);
      decision_done    = 1'b0;
      decision_allowed = 1'($urandom_range(1));
      if (allowed) begin
        receive(pkt, mode, cyc);
      end else begin
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_drop", 32'(in_ready), 32'd0);
        exp_drop++;
        @(negedge clk);
        check("in_ready_after_drop", 32'(in_ready), 32'd1);
        check("out_valid_after_drop", 32'(out_valid), 32'd0);
        check_counts("after_drop");
      end
    end else begin
      repeat (TIMEOUT) begin
        check("out_valid_wait", 32'(out_valid), 32'd0);
        check("in_ready_wait_loop", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
      check("in_ready_tmo_drop", 32'(in_ready), 32'd0);
      check("out_valid_tmo_drop", 32'(out_valid), 32'd0);
      exp_tmo++;
      @(negedge clk);
      check("in_ready_after_tmo", 32'(in_ready), 32'd1);
      check_counts("after_tmo");
      decision_done    = 1'b1;
      decision_allowed = 1'b1;
      @(negedge clk);
      decision_done = 1'b0;
      check("late_done_out_valid", 32'(out_valid), 32'd0);
      check("late_done_in_ready", 32'(in_ready), 32'd1);
      check_counts("late_done");
    end
  endtask

  // Asynchronous reset pulse raised between clock edges.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    exp_fwd  = 0;
    exp_drop = 0;
    exp_tmo  = 0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_counts("rst");
    valid_in      = 1'b0;
    decision_done = 1'b0;
    out_ready     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    byte_q_t pkt;
    int      cyc;
    int      d;
    int      sel;
    logic    allowed;

    rst              = 1'b1;
    data_in          = 8'h00;
    valid_in         = 1'b0;
    decision_done    = 1'b0;
    decision_allowed = 1'b0;
    out_ready        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_last", 32'(out_last), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check_counts("reset");
    rst = 1'b0;
    @(negedge clk);

    // Sequential packet forwarded, verdict three cycles after last byte.
    pkt = seq_pkt(PKT_LEN);
    send_bytes(pkt, 0, -1);
    decide(pkt, 2, 1'b1, 0);

    // Same packet dropped by verdict.
    send_bytes(pkt, 0, -1);
    decide(pkt, 2, 1'b0, 0);

    // No verdict: forced drop, late pulse ignored.
    send_bytes(pkt, 0, -1);
    decide(pkt, TIMEOUT, 1'b1, 0);

    // Egress with out_ready alternating 0/1: two cycles per byte.
    pkt = rand_pkt();
    send_bytes(pkt, 0, -1);
    check("in_ready_wait_t4", 32'(in_ready), 32'd0);
    decision_done    = 1'b1;
    decision_allowed = 1'b1;
    @(negedge clk);
    decision_done = 1'b0;
    receive(pkt, 1, cyc);
    check("toggle_egress_cycles", 32'(cyc), 32'(2 * PKT_LEN));

    // Early pulse during capture is ignored; the real verdict is obeyed.
    pkt = rand_pkt();
    send_bytes(pkt, 0, 20);
    decide(pkt, 4, 1'b1, 2);

    // Verdict on the final timer cycle wins over the timeout.
    pkt = rand_pkt();
    send_bytes(pkt, 10, -1);
    decide(pkt, TIMEOUT - 1, 1'b1, 0);
    pkt = rand_pkt();
    send_bytes(pkt, 0, -1);
    decide(pkt, TIMEOUT - 1, 1'b0, 0);

    // Reset during forwarding after ten bytes.
    pkt = rand_pkt();
    send_bytes(pkt, 0, -1);
    decision_done    = 1'b1;
    decision_allowed = 1'b1;
    @(negedge clk);
    decision_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("pre_rst_data", 32'(out_data), 32'(pkt[i]));
      out_ready = 1'b1;
      @(negedge clk);
    end
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    pulse_reset();
    pkt = rand_pkt();
    send_bytes(pkt, 0, -1);
    decide(pkt, 1, 1'b1, 0);

    // Reset mid-capture and mid-wait abandon the packet.
    send_bytes(seq_pkt(15), 0, -1);
    pulse_reset();
    pkt = rand_pkt();
    send_bytes(pkt, 0, -1);
    repeat (5) @(negedge clk);
    pulse_reset();
    pkt = rand_pkt();
    send_bytes(pkt, 20, -1);
    decide(pkt, 0, 1'b1, 2);

    // Drop counter saturates at all-ones.
    for (int n = 0; n < CMAX + 2; n++) begin
      pkt = rand_pkt();
      send_bytes(pkt, 0, -1);
      decide(pkt, 0, 1'b0, 0);
    end

    // Randomized packets against the model.
    for (int n = 0; n < 16; n++) begin
      pkt = rand_pkt();
      send_bytes(pkt, 30, (int'($urandom_range(3)) == 0) ? int'($urandom_range(PKT_LEN - 1)) : -1);
      sel = int'($urandom_range(4));
      case (sel)
        0:       d = 0;
        1:       d = TIMEOUT - 1;
        2:       d = TIMEOUT;
        default: d = int'($urandom_range(TIMEOUT + 5));
      endcase
      allowed = 1'($urandom_range(1));
      decide(pkt, d, allowed, int'($urandom_range(2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_gate.md
PACKET_GATE -- requirements
Module: packet_gate

Interface
REQ-001 Parameter PKT_LEN, default 40, meaning fixed packet length in bytes (range 2..64).
REQ-002 Parameter TIMEOUT, default 1024, meaning max cycles in WAIT_DEC before forced drop (range 2..65535).
REQ-003 Parameter CNT_W, default 16, meaning width of statistics counters.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 data_in  input  8  ingress byte, same byte stream fed to the filter stage.
REQ-007 valid_in  input  1  ingress byte valid.
REQ-008 in_ready  output  1  gate can accept a byte; a byte transfers when valid_in && in_ready.
REQ-009 decision_done  input  1  one-cycle pulse from filter: verdict valid.
REQ-010 decision_allowed  input  1  verdict, 1 = forward, 0 = drop; sampled only with decision_done.
REQ-011 out_data  output  8  egress byte.
REQ-012 out_valid  output  1  egress byte valid.
REQ-013 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-014 out_last  output  1  marks final byte of packet on egress.
REQ-015 fwd_count  output  CNT_W  packets forwarded, saturating.
REQ-016 drop_count  output  CNT_W  packets dropped by verdict, saturating.
REQ-017 timeout_count  output  CNT_W  packets dropped by timeout, saturating.

Function
REQ-018 Block SHALL buffer one PKT_LEN-byte packet in internal storage, then forward or discard it per the filter verdict.
REQ-019 FSM states SHALL be IDLE, CAPTURE, WAIT_DEC, FORWARD, DROP.
REQ-020 in_ready SHALL be 1 in IDLE and CAPTURE, 0 in all other states.
REQ-021 IDLE: accepted byte written to buf[0], write pointer set to 1, go CAPTURE.
REQ-022 CAPTURE: each accepted byte written to buf[wr_ptr], wr_ptr incremented; cycles without valid_in hold state.
REQ-023 Acceptance of byte index PKT_LEN-1 SHALL move to WAIT_DEC and clear the wait timer to 0.
REQ-024 decision_done SHALL be ignored in every state except WAIT_DEC.
REQ-025 WAIT_DEC: decision_done && decision_allowed -> FORWARD with read pointer 0; decision_done && !decision_allowed -> DROP.
REQ-026 WAIT_DEC without decision_done: timer increments; when timer == TIMEOUT-1 go DROP flagged as timeout.
REQ-027 decision_done in the same cycle as timer == TIMEOUT-1 SHALL take precedence over timeout.
REQ-028 FORWARD: out_valid = 1, out_data = buf[rd_ptr], out_last = (rd_ptr == PKT_LEN-1); out_valid is 0 in all other states.
REQ-029 out_data, out_last SHALL hold stable while out_valid && !out_ready.
REQ-030 Transfer of the last byte SHALL increment fwd_count and return to IDLE next cycle.
REQ-031 DROP SHALL last exactly one cycle, increment drop_count (verdict) or timeout_count (timeout), then go IDLE.
REQ-032 Counters SHALL saturate at all-ones and never wrap.
REQ-033 Minimum packet-to-packet spacing: next packet's first byte accepted no earlier than the cycle after FORWARD/DROP exits.
REQ-034 Latency: first egress byte valid one cycle after the decision_done cycle.

Reset
REQ-035 rst SHALL asynchronously force IDLE, clear pointers, timer and all counters; out_valid = 0, out_last = 0, out_data = 0, in_ready = 1.
REQ-036 rst asserted mid-CAPTURE, WAIT_DEC or FORWARD SHALL abandon the packet without incrementing any counter.
REQ-037 Buffer contents need not be cleared by reset.

Verification
REQ-038 40 bytes 0x00..0x27 back-to-back, decision_done=1/allowed=1 three cycles later, out_ready=1 -> 40 egress bytes 0x00..0x27, out_last on 0x27 only, fwd_count=1.
REQ-039 Same packet, allowed=0 -> no out_valid, drop_count=1, in_ready=1 two cycles after verdict.
REQ-040 Packet captured, no decision_done for TIMEOUT cycles -> timeout_count=1, no egress; done pulse arriving afterwards ignored.
REQ-041 Forward with out_ready toggled 1/0 every cycle -> byte order intact, out_data stable during stalls, 80 cycles of egress.
REQ-042 decision_done pulse during CAPTURE (byte 20), then real verdict in WAIT_DEC -> early pulse ignored, real verdict obeyed.
REQ-043 rst pulse during FORWARD at byte 10 -> out_valid=0 immediately, all counters 0, next packet handled normally.
